memory_bus_arbiter: RTL and testbench

Time-shares the single memory-router request port between the CPU, the DMA controller and the PPU. Each requester presents an address plus active-low read/write strobes and is held off with a wait flag until its access has occupied the shared port for a fixed number of cycles. The arbiter drives the router's request side and reports the current owner so the router can steer the bidirectional data bus. It sits between `cpu`/`dma_controller`/PPU and `memory_router`.

---
 rtl/memory_bus_arbiter.sv | 168 ++++++++++++++++
 tb/tb_memory_bus_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/memory_bus_arbiter.sv
// Three-way arbiter (PPU > DMA > CPU) that time-shares the memory-router request port.
// Define ARB_STARVE_GUARD_EN to let a starved CPU win after STARVE_LIMIT arbitration losses.
module memory_bus_arbiter #(
  parameter int ACCESS_CYCLES = 2,
  parameter int STARVE_LIMIT  = 8
) (
  input  logic        I_CLK,
  input  logic        I_SYNC_RESET,
  input  logic [15:0] I_CPU_ADDR,
  input  logic        I_CPU_WE_L,
  input  logic        I_CPU_RE_L,
  output logic        O_CPU_WAIT,
  input  logic [15:0] I_DMA_ADDR,
  input  logic        I_DMA_WE_L,
  input  logic        I_DMA_RE_L,
  output logic        O_DMA_WAIT,
  input  logic [15:0] I_PPU_ADDR,
  input  logic        I_PPU_RE_L,
  output logic        O_PPU_WAIT,
  output logic [15:0] O_MEM_ADDR,
  output logic        O_MEM_WE_L,
  output logic        O_MEM_RE_L,
  output logic [1:0]  O_GRANT
);

  typedef enum logic {IDLE, ACCESS} state_t;

  localparam logic [1:0] G_NONE = 2'd0;
  localparam logic [1:0] G_CPU  = 2'd1;
  localparam logic [1:0] G_DMA  = 2'd2;
  localparam logic [1:0] G_PPU  = 2'd3;
  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  if (ACCESS_CYCLES < 1 || ACCESS_CYCLES > 15) begin : g_bad_access
    $error("ACCESS_CYCLES out of range 1..15");
  end
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve
    $error("STARVE_LIMIT out of range 1..15");
  end

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic [1:0]  grant_next;
  logic [15:0] addr_next;
  logic        we_l_next, re_l_next;

  logic cpu_req, dma_req, ppu_req;
  logic cand_cpu, cand_dma, cand_ppu;
  logic arb_now, final_cycle;
  logic [1:0]  winner;
  logic [15:0] win_addr;
  logic        win_write;

  assign cpu_req = ~I_CPU_WE_L | ~I_CPU_RE_L;
  assign dma_req = ~I_DMA_WE_L | ~I_DMA_RE_L;
  assign ppu_req = ~I_PPU_RE_L;

  assign final_cycle = (state == ACCESS) && (cnt == 4'd0);
  assign arb_now     = (state == IDLE) || final_cycle;

  // O_GRANT is G_NONE in IDLE, so this only excludes the owner finishing its access.
  assign cand_cpu = cpu_req && (O_GRANT != G_CPU);
  assign cand_dma = dma_req && (O_GRANT != G_DMA);
  assign cand_ppu = ppu_req && (O_GRANT != G_PPU);

`ifdef ARB_STARVE_GUARD_EN
  logic [3:0] starve, starve_next;
  logic       cpu_forced;
  assign cpu_forced = cand_cpu && (starve >= 4'(STARVE_LIMIT));
`endif

  always_comb begin
    winner = G_NONE;
    if (cand_ppu)      winner = G_PPU;
    else if (cand_dma) winner = G_DMA;
    else if (cand_cpu) winner = G_CPU;
`ifdef ARB_STARVE_GUARD_EN
    if (cpu_forced)    winner = G_CPU;
`endif
  end

  // A write wins over a read when a requester drives both strobes low.
  always_comb begin
    win_addr  = I_CPU_ADDR;
    win_write = ~I_CPU_WE_L;
    case (winner)
      G_DMA: begin
        win_addr  = I_DMA_ADDR;
        win_write = ~I_DMA_WE_L;
      end
      G_PPU: begin
        win_addr  = I_PPU_ADDR;
        win_write = 1'b0;
      end
      default: ;
    endcase
  end

  // NOTE: every next-state signal gets a hold default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    grant_next = O_GRANT;
    addr_next  = O_MEM_ADDR;
    we_l_next  = O_MEM_WE_L;
    re_l_next  = O_MEM_RE_L;
    if (state == ACCESS && cnt != 4'd0) cnt_next = cnt - 4'd1;
    if (arb_now) begin
      if (winner != G_NONE) begin
        state_next = ACCESS;
        cnt_next   = CNT_LOAD;
        grant_next = winner;
        addr_next  = win_addr;
        we_l_next  = ~win_write;
        re_l_next  = win_write;
      end else begin
        state_next = IDLE;
        cnt_next   = 4'd0;
        grant_next = G_NONE;
        we_l_next  = 1'b1;
        re_l_next  = 1'b1;
      end
    end
  end

`ifdef ARB_STARVE_GUARD_EN
  always_comb begin
    starve_next = starve;
    if (!cpu_req) begin
      starve_next = 4'd0;
    end else if (arb_now) begin
      if (winner == G_CPU)                   starve_next = 4'd0;
      else if (cand_cpu && starve != 4'd15)  starve_next = starve + 4'd1;
    end
  end
`endif

  // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge I_CLK) begin
    if (I_SYNC_RESET) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      O_GRANT    <= G_NONE;
      O_MEM_ADDR <= 16'h0000;
      O_MEM_WE_L <= 1'b1;
      O_MEM_RE_L <= 1'b1;
`ifdef ARB_STARVE_GUARD_EN
      starve     <= 4'd0;
`endif
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      O_GRANT    <= grant_next;
      O_MEM_ADDR <= addr_next;
      O_MEM_WE_L <= we_l_next;
      O_MEM_RE_L <= re_l_next;
`ifdef ARB_STARVE_GUARD_EN
      starve     <= starve_next;
`endif
    end
  end

  // Wait drops only in the owner's final cycle; reset suppresses the completion indication.
  assign O_CPU_WAIT = cpu_req && !(!I_SYNC_RESET && final_cycle && O_GRANT == G_CPU);
  assign O_DMA_WAIT = dma_req && !(!I_SYNC_RESET && final_cycle && O_GRANT == G_DMA);
  assign O_PPU_WAIT = ppu_req && !(!I_SYNC_RESET && final_cycle && O_GRANT == G_PPU);

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Self-checking bench for memory_bus_arbiter: vector table through a scoreboard queue,
// plus hand-written ACCESS_CYCLES=1 and starvation sequences.
module tb_memory_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr, dma_addr, ppu_addr;
  logic        cpu_we_l, cpu_re_l, dma_we_l, dma_re_l, ppu_re_l;
  logic        cpu_wait, dma_wait, ppu_wait;
  logic [15:0] mem_addr;
  logic        mem_we_l, mem_re_l;
  logic [1:0]  grant;
  logic        cpu_wait1, dma_wait1, ppu_wait1;
  logic [15:0] mem_addr1;
  logic        mem_we_l1, mem_re_l1;
  logic [1:0]  grant1;

  always #5 clk = ~clk;

  memory_bus_arbiter #(.ACCESS_CYCLES(2), .STARVE_LIMIT(3)) dut (
    .I_CLK(clk), .I_SYNC_RESET(rst),
    .I_CPU_ADDR(cpu_addr), .I_CPU_WE_L(cpu_we_l), .I_CPU_RE_L(cpu_re_l), .O_CPU_WAIT(cpu_wait),
    .I_DMA_ADDR(dma_addr), .I_DMA_WE_L(dma_we_l), .I_DMA_RE_L(dma_re_l), .O_DMA_WAIT(dma_wait),
    .I_PPU_ADDR(ppu_addr), .I_PPU_RE_L(ppu_re_l), .O_PPU_WAIT(ppu_wait),
    .O_MEM_ADDR(mem_addr), .O_MEM_WE_L(mem_we_l), .O_MEM_RE_L(mem_re_l), .O_GRANT(grant)
  );

  memory_bus_arbiter #(.ACCESS_CYCLES(1), .STARVE_LIMIT(3)) dut1 (
    .I_CLK(clk), .I_SYNC_RESET(rst),
    .I_CPU_ADDR(cpu_addr), .I_CPU_WE_L(cpu_we_l), .I_CPU_RE_L(cpu_re_l), .O_CPU_WAIT(cpu_wait1),
    .I_DMA_ADDR(dma_addr), .I_DMA_WE_L(dma_we_l), .I_DMA_RE_L(dma_re_l), .O_DMA_WAIT(dma_wait1),
    .I_PPU_ADDR(ppu_addr), .I_PPU_RE_L(ppu_re_l), .O_PPU_WAIT(ppu_wait1),
    .O_MEM_ADDR(mem_addr1), .O_MEM_WE_L(mem_we_l1), .O_MEM_RE_L(mem_re_l1), .O_GRANT(grant1)
  );

  // Ops: 0 idle, 1 read, 2 write, 3 both strobes low. Expected eop: 0 idle, 1 read, 2 write.
  typedef struct {
    logic        rst;
    logic [1:0]  cop;  logic [15:0] ca;
    logic [1:0]  dop;  logic [15:0] da;
    logic        pop;  logic [15:0] pa;
    logic [1:0]  g;    logic [15:0] ea;
    logic        chk_a;
    logic [1:0]  eop;
    logic [2:0]  ew;   // {cpu, dma, ppu} wait
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  logic [1:0] gexp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic [1:0] cop, input logic [15:0] ca,
                              input logic [1:0] dop, input logic [15:0] da,
                              input logic pop, input logic [15:0] pa,
                              input logic [1:0] g, input logic [15:0] ea, input logic chk_a,
                              input logic [1:0] eop, input logic [2:0] ew);
    vec_t v;
    v.rst = r; v.cop = cop; v.ca = ca; v.dop = dop; v.da = da; v.pop = pop; v.pa = pa;
    v.g = g; v.ea = ea; v.chk_a = chk_a; v.eop = eop; v.ew = ew;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rst      = v.rst;
    cpu_addr = v.ca;
    cpu_we_l = ~v.cop[1];
    cpu_re_l = ~v.cop[0];
    dma_addr = v.da;
    dma_we_l = ~v.dop[1];
    dma_re_l = ~v.dop[0];
    ppu_addr = v.pa;
    ppu_re_l = ~v.pop;
  endtask

  task automatic step(input vec_t v, input int idx);
    vec_t e;
    drive(v);
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check($sformatf("v%0d grant", idx), {14'd0, grant}, {14'd0, e.g});
    if (e.chk_a) check($sformatf("v%0d addr", idx), mem_addr, e.ea);
    check($sformatf("v%0d we_l", idx), {15'd0, mem_we_l}, {15'd0, e.eop != 2'd2});
    check($sformatf("v%0d re_l", idx), {15'd0, mem_re_l}, {15'd0, e.eop != 2'd1});
    check($sformatf("v%0d waits", idx), {13'd0, cpu_wait, dma_wait, ppu_wait}, {13'd0, e.ew});
  endtask

  initial begin
    vec_t v;
    // reset
    tbl.push_back(mk(1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 0, 3'b000));
    // single CPU read on an idle bus
    tbl.push_back(mk(0, 1, 16'hC000, 0, 16'h0000, 0, 16'h0000, 1, 16'hC000, 1, 1, 3'b100));
    tbl.push_back(mk(0, 1, 16'hC000, 0, 16'h0000, 0, 16'h0000, 1, 16'hC000, 1, 1, 3'b000));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 3'b000));
    // simultaneous requests: PPU, DMA, CPU back to back
    tbl.push_back(mk(0, 1, 16'hC010, 2, 16'hFE00, 1, 16'h8000, 3, 16'h8000, 1, 1, 3'b111));
    tbl.push_back(mk(0, 1, 16'hC010, 2, 16'hFE00, 1, 16'h8000, 3, 16'h8000, 1, 1, 3'b110));
    tbl.push_back(mk(0, 1, 16'hC010, 2, 16'hFE00, 0, 16'h0000, 2, 16'hFE00, 1, 2, 3'b110));
    tbl.push_back(mk(0, 1, 16'hC010, 2, 16'hFE00, 0, 16'h0000, 2, 16'hFE00, 1, 2, 3'b100));
    tbl.push_back(mk(0, 1, 16'hC010, 0, 16'h0000, 0, 16'h0000, 1, 16'hC010, 1, 1, 3'b100));
    tbl.push_back(mk(0, 1, 16'hC010, 0, 16'h0000, 0, 16'h0000, 1, 16'hC010, 1, 1, 3'b000));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 3'b000));
    // DMA with both strobes low is a write
    tbl.push_back(mk(0, 0, 16'h0000, 3, 16'h2000, 0, 16'h0000, 2, 16'h2000, 1, 2, 3'b010));
    tbl.push_back(mk(0, 0, 16'h0000, 3, 16'h2000, 0, 16'h0000, 2, 16'h2000, 1, 2, 3'b000));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 3'b000));
    // CPU address change mid-access is ignored
    tbl.push_back(mk(0, 1, 16'h4000, 0, 16'h0000, 0, 16'h0000, 1, 16'h4000, 1, 1, 3'b100));
    tbl.push_back(mk(0, 1, 16'h1234, 0, 16'h0000, 0, 16'h0000, 1, 16'h4000, 1, 1, 3'b000));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 3'b000));
    // CPU withdraws mid-access: access completes, then idle
    tbl.push_back(mk(0, 2, 16'h5000, 0, 16'h0000, 0, 16'h0000, 1, 16'h5000, 1, 2, 3'b100));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 16'h5000, 1, 2, 3'b000));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 3'b000));
    // same-owner re-request needs one idle cycle
    tbl.push_back(mk(0, 1, 16'h6000, 0, 16'h0000, 0, 16'h0000, 1, 16'h6000, 1, 1, 3'b100));
    tbl.push_back(mk(0, 1, 16'h6000, 0, 16'h0000, 0, 16'h0000, 1, 16'h6000, 1, 1, 3'b000));
    tbl.push_back(mk(0, 1, 16'h6000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 3'b100));
    tbl.push_back(mk(0, 1, 16'h6000, 0, 16'h0000, 0, 16'h0000, 1, 16'h6000, 1, 1, 3'b100));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 16'h6000, 1, 1, 3'b000));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 3'b000));
    // reset during a DMA access with cnt = 1: no completion pulse
    tbl.push_back(mk(0, 0, 16'h0000, 1, 16'h7000, 0, 16'h0000, 2, 16'h7000, 1, 1, 3'b010));
    tbl.push_back(mk(1, 0, 16'h0000, 1, 16'h7000, 0, 16'h0000, 0, 16'h0000, 1, 0, 3'b010));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 0, 3'b000));

    v = tbl[0];
    drive(v);
    #1;
    for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);

    // ACCESS_CYCLES = 1: re-arbitrates every edge, wait low in the grant cycle
    cpu_addr = 16'hD000; cpu_we_l = 1'b1; cpu_re_l = 1'b0;
    dma_addr = 16'hE000; dma_we_l = 1'b1; dma_re_l = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("ac1 grant %0d", i), {14'd0, grant1}, (i % 2 == 0) ? 16'd2 : 16'd1);
      check($sformatf("ac1 addr %0d", i), mem_addr1, (i % 2 == 0) ? 16'hE000 : 16'hD000);
      check($sformatf("ac1 waits %0d", i), {14'd0, cpu_wait1, dma_wait1},
            (i % 2 == 0) ? 16'd2 : 16'd1);
    end

    // starvation: all three requesting continuously from idle
    v = mk(1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 0, 3'b000);
    step(v, 100);
    rst = 1'b0;
    cpu_addr = 16'hA000; cpu_we_l = 1'b1; cpu_re_l = 1'b0;
    dma_addr = 16'hB000; dma_we_l = 1'b1; dma_re_l = 1'b0;
    ppu_addr = 16'h9000; ppu_re_l = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
    gexp_q = '{2'd3, 2'd3, 2'd2, 2'd2, 2'd3, 2'd3, 2'd1, 2'd1, 2'd3, 2'd3, 2'd2, 2'd2};
`else
    gexp_q = '{2'd3, 2'd3, 2'd2, 2'd2, 2'd3, 2'd3, 2'd2, 2'd2, 2'd3, 2'd3, 2'd2, 2'd2};
`endif
    for (int i = 0; i < 12; i++) begin
      logic [1:0] ge;
      @(posedge clk);
      #1;
      ge = gexp_q.pop_front();
      check($sformatf("starve grant %0d", i), {14'd0, grant}, {14'd0, ge});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
